// File: rtl/imem_loader_pkg.sv
// Shared definitions for the boot-stream instruction-memory loader.
package imem_loader_pkg;

  localparam int DEPTH_DEF  = 1024;
  localparam int ADDR_W_DEF = 10;
  localparam int LEN_W      = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN0,
    S_LEN1,
    S_DATA,
    S_WRITE,
    S_DONE,
    S_ERROR
  } state_t;

endpackage

// File: rtl/imem_loader_word_assembler.sv
// Packs a little-endian byte stream into 32-bit words, flagging the fourth byte.
module word_assembler (
  input  logic        clk,
  input  logic        rst,
  input  logic        clear_i,
  input  logic        byte_stb_i,
  input  logic [7:0]  byte_i,
  output logic [31:0] word_o,
  output logic        word_full_o
);

  logic [1:0]  cnt_q, cnt_d;
  logic [31:0] shreg_q, shreg_d;

  // Bytes enter at the top and shift down, so the first byte ends in [7:0].
  always_comb begin
    cnt_d   = cnt_q;
    shreg_d = shreg_q;
    if (clear_i) begin
      cnt_d   = 2'd0;
      shreg_d = 32'd0;
    end else if (byte_stb_i) begin
      cnt_d   = cnt_q + 2'd1;
      shreg_d = {byte_i, shreg_q[31:8]};
    end
  end

  assign word_o      = {byte_i, shreg_q[31:8]};
  assign word_full_o = byte_stb_i && (cnt_q == 2'd3);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= 2'd0;
      shreg_q <= 32'd0;
    end else begin
      cnt_q   <= cnt_d;
      shreg_q <= shreg_d;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Boot loader: reads a 16-bit little-endian word count and then that many
// 32-bit words from a byte stream, writing them to instruction memory.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int DEPTH  = DEPTH_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_byte,
  output logic              in_ready,
  output logic              we,
  output logic [ADDR_W-1:0] waddr,
  output logic [31:0]       wdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              core_rst_n
);

  state_t             state_q, state_d;
  logic [LEN_W-1:0]   count_q, count_d;
  logic [ADDR_W-1:0]  idx_q, idx_d;
  logic [31:0]        wdata_q, wdata_d;

  logic               xfer;
  logic [LEN_W-1:0]   hdr;
  logic               last_word;
  logic               asm_clear;
  logic               asm_stb;
  logic [31:0]        asm_word;
  logic               asm_full;

  assign xfer      = in_valid && in_ready;
  assign hdr       = {in_byte, count_q[7:0]};
  assign last_word = (LEN_W'(idx_q) + LEN_W'(1)) == count_q;
  assign asm_stb   = xfer && (state_q == S_DATA);

  word_assembler u_asm (
    .clk         (clk),
    .rst         (rst),
    .clear_i     (asm_clear),
    .byte_stb_i  (asm_stb),
    .byte_i      (in_byte),
    .word_o      (asm_word),
    .word_full_o (asm_full)
  );

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    idx_d     = idx_q;
    wdata_d   = wdata_q;
    asm_clear = 1'b0;
    unique case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start) begin
          state_d   = S_LEN0;
          idx_d     = '0;
          asm_clear = 1'b1;
        end
      end
      S_LEN0: begin
        if (xfer) begin
          count_d[7:0] = in_byte;
          state_d      = S_LEN1;
        end
      end
      S_LEN1: begin
        // The header is judged from the live high byte so DATA starts without an extra cycle.
        if (xfer) begin
          count_d[15:8] = in_byte;
          if (hdr == '0)
            state_d = S_DONE;
          else if (int'(hdr) > DEPTH)
            state_d = S_ERROR;
          else
            state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (asm_full) begin
          wdata_d = asm_word;
          state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        // The final index is kept rather than stepped, so waddr never wraps past DEPTH-1.
        if (last_word) begin
          state_d = S_DONE;
        end else begin
          idx_d   = idx_q + ADDR_W'(1);
          state_d = S_DATA;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      count_q <= '0;
      idx_q   <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
    end
  end

  assign in_ready   = (state_q == S_LEN0) || (state_q == S_LEN1) || (state_q == S_DATA);
  assign we         = (state_q == S_WRITE);
  assign busy       = in_ready || we;
  assign done       = (state_q == S_DONE);
  assign err        = (state_q == S_ERROR);
  assign core_rst_n = (state_q == S_DONE);
  assign waddr      = idx_q;
  assign wdata      = wdata_q;

endmodule

// File: tb/tb_imem_loader.sv
// Randomized self-checking bench for imem_loader against a stream-level model.
module tb_imem_loader;

  localparam int DEPTH  = 1024;
  localparam int ADDR_W = 10;

  typedef logic [7:0] bq_t[$];

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic              in_valid = 1'b0;
  logic [7:0]        in_byte = 8'd0;
  logic              in_ready;
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [31:0]       wdata;
  logic              busy;
  logic              done;
  logic              err;
  logic              core_rst_n;

  imem_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .in_valid   (in_valid),
    .in_byte    (in_byte),
    .in_ready   (in_ready),
    .we         (we),
    .waddr      (waddr),
    .wdata      (wdata),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .core_rst_n (core_rst_n)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Observed memory writes and in_ready seen high during a write cycle.
  logic [ADDR_W-1:0] wr_a[$];
  logic [31:0]       wr_d[$];
  int                rdy_viol = 0;

  always @(negedge clk) begin
    if (we) begin
      wr_a.push_back(waddr);
      wr_d.push_back(wdata);
      if (in_ready) rdy_viol++;
    end
  end

  // Reference: header gives the word count, words follow little-endian, indices from 0.
  logic [ADDR_W-1:0] ex_a[$];
  logic [31:0]       ex_d[$];
  bit                ex_done;
  bit                ex_err;

  task automatic model(input bq_t s);
    int n;
    n = int'(s[0]) + 256 * int'(s[1]);
    ex_a.delete();
    ex_d.delete();
    ex_done = 1'b0;
    ex_err  = 1'b0;
    if (n > DEPTH) begin
      ex_err = 1'b1;
    end else begin
      ex_done = 1'b1;
      for (int w = 0; w < n; w++) begin
        ex_a.push_back(ADDR_W'(w));
        ex_d.push_back({s[2+4*w+3], s[2+4*w+2], s[2+4*w+1], s[2+4*w]});
      end
    end
  endtask

  function automatic bq_t mk(input int hdr, input int nw);
    bq_t s;
    s.push_back(8'(hdr));
    s.push_back(8'(hdr >> 8));
    for (int i = 0; i < 4 * nw; i++) s.push_back(8'($urandom));
    return s;
  endfunction

  task automatic clear_obs();
    wr_a.delete();
    wr_d.delete();
    rdy_viol = 0;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // mode 0: unthrottled, 1: in_valid toggles between bytes, 2: random gaps.
  task automatic send_bytes(input bq_t s, input int mode, output bit to);
    int g;
    to = 1'b0;
    for (int i = 0; i < s.size(); i++) begin
      if (mode == 1 && i > 0) begin
        in_valid = 1'b0;
        @(negedge clk);
      end else if (mode == 2) begin
        repeat ($urandom_range(0, 2)) begin
          in_valid = 1'b0;
          @(negedge clk);
        end
      end
      in_valid = 1'b1;
      in_byte  = s[i];
      g = 0;
      while (!in_ready && g < 20) begin
        @(negedge clk);
        g++;
      end
      if (!in_ready) begin
        to = 1'b1;
        break;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_end(output int lat, output bit to);
    lat = 0;
    while (!(done || err) && lat < 60) begin
      @(negedge clk);
      lat++;
    end
    to = !(done || err);
  endtask

  task automatic run_session(input bq_t s, input int mode, output bit to);
    bit t1, t2;
    int lat;
    pulse_start();
    send_bytes(s, mode, t1);
    wait_end(lat, t2);
    to = t1 || t2;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    total++;
    if ({we, in_ready, busy, done, err, core_rst_n} !== 6'b0) begin
      bad++;
      $display("FAIL reset_ctrl got=%b exp=000000", {we, in_ready, busy, done, err, core_rst_n});
    end
    total++;
    if (waddr !== '0 || wdata !== 32'd0) begin
      bad++;
      $display("FAIL reset_data got=%0h/%0h exp=0/0", waddr, wdata);
    end
    rst = 1'b0;
    in_valid = 1'b1;
    in_byte  = 8'h5A;
    repeat (3) @(negedge clk);
    in_valid = 1'b0;
    total++;
    if (busy !== 1'b0 || in_ready !== 1'b0) begin
      bad++;
      $display("FAIL reset_idle_hold got=%b%b exp=00", busy, in_ready);
    end
  endtask

  task automatic test_basic();
    bq_t s;
    bit to;
    s = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h50, 8'h00, 8'hB3, 8'hE2, 8'h62, 8'h00};
    model(s);
    clear_obs();
    run_session(s, 0, to);
    total++;
    if (to) begin bad++; $display("FAIL basic_timeout got=1 exp=0"); end
    total++;
    if (wr_a.size() != 2) begin
      bad++;
      $display("FAIL basic_nwr got=%0d exp=2", wr_a.size());
    end else begin
      total++;
      if (wr_a[0] !== 10'd0 || wr_d[0] !== 32'h00500013) begin
        bad++;
        $display("FAIL basic_w0 got=%0d/%h exp=0/00500013", wr_a[0], wr_d[0]);
      end
      total++;
      if (wr_a[1] !== 10'd1 || wr_d[1] !== 32'h0062E2B3) begin
        bad++;
        $display("FAIL basic_w1 got=%0d/%h exp=1/0062e2b3", wr_a[1], wr_d[1]);
      end
    end
    total++;
    if (done !== 1'b1 || core_rst_n !== 1'b1 || busy !== 1'b0 || err !== 1'b0) begin
      bad++;
      $display("FAIL basic_status got=d%b r%b b%b e%b exp=d1 r1 b0 e0", done, core_rst_n, busy, err);
    end
    total++;
    if (wdata !== 32'h0062E2B3) begin
      bad++;
      $display("FAIL basic_wdata_hold got=%h exp=0062e2b3", wdata);
    end
  endtask

  task automatic test_zero_len();
    bq_t s;
    bit t1, t2;
    int lat;
    s = '{8'h00, 8'h00};
    clear_obs();
    pulse_start();
    send_bytes(s, 0, t1);
    wait_end(lat, t2);
    total++;
    if (t1 || t2 || lat > 1) begin
      bad++;
      $display("FAIL zero_latency got=%0d exp<=1 (timeout=%0d)", lat, t1 || t2);
    end
    total++;
    if (wr_a.size() != 0 || done !== 1'b1 || core_rst_n !== 1'b1) begin
      bad++;
      $display("FAIL zero_result got=nwr%0d d%b r%b exp=nwr0 d1 r1", wr_a.size(), done, core_rst_n);
    end
  endtask

  task automatic test_overflow();
    bq_t s;
    bit to;
    s = '{8'h01, 8'h04};
    model(s);
    clear_obs();
    run_session(s, 0, to);
    total++;
    if (to || err !== ex_err || core_rst_n !== 1'b0 || done !== 1'b0 || wr_a.size() != 0) begin
      bad++;
      $display("FAIL ovf_status got=e%b r%b d%b nwr%0d exp=e1 r0 d0 nwr0", err, core_rst_n, done, wr_a.size());
    end
    in_valid = 1'b1;
    in_byte  = 8'hC3;
    repeat (3) @(negedge clk);
    total++;
    if (in_ready !== 1'b0 || err !== 1'b1) begin
      bad++;
      $display("FAIL ovf_no_consume got=rdy%b e%b exp=rdy0 e1", in_ready, err);
    end
    in_valid = 1'b0;
    s = mk(1, 1);
    model(s);
    clear_obs();
    run_session(s, 0, to);
    total++;
    if (to || err !== 1'b0 || done !== 1'b1 || wr_a.size() != 1) begin
      bad++;
      $display("FAIL ovf_recover got=e%b d%b nwr%0d exp=e0 d1 nwr1", err, done, wr_a.size());
    end else begin
      total++;
      if (wr_a[0] !== ex_a[0] || wr_d[0] !== ex_d[0]) begin
        bad++;
        $display("FAIL ovf_recover_w got=%0d/%h exp=%0d/%h", wr_a[0], wr_d[0], ex_a[0], ex_d[0]);
      end
    end
  endtask

  task automatic test_start_with_byte();
    bq_t s;
    bit t1, t2;
    int lat;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    s = mk(1, 1);
    model(s);
    clear_obs();
    start    = 1'b1;
    in_valid = 1'b1;
    in_byte  = 8'hAA;
    @(negedge clk);
    start = 1'b0;
    send_bytes(s, 0, t1);
    wait_end(lat, t2);
    total++;
    if (t1 || t2 || done !== 1'b1 || wr_a.size() != 1) begin
      bad++;
      $display("FAIL start_byte got=d%b e%b nwr%0d exp=d1 e0 nwr1", done, err, wr_a.size());
    end else begin
      total++;
      if (wr_a[0] !== ex_a[0] || wr_d[0] !== ex_d[0]) begin
        bad++;
        $display("FAIL start_byte_w got=%0d/%h exp=%0d/%h", wr_a[0], wr_d[0], ex_a[0], ex_d[0]);
      end
    end
  endtask

  task automatic test_throttle();
    bq_t s;
    bit to;
    logic [ADDR_W-1:0] a0[$];
    logic [31:0]       d0[$];
    s = mk(6, 6);
    model(s);
    clear_obs();
    run_session(s, 0, to);
    a0 = wr_a;
    d0 = wr_d;
    clear_obs();
    run_session(s, 1, to);
    total++;
    if (to || wr_a.size() != ex_a.size() || a0.size() != ex_a.size()) begin
      bad++;
      $display("FAIL thr_nwr got=%0d/%0d exp=%0d", a0.size(), wr_a.size(), ex_a.size());
    end else begin
      for (int i = 0; i < ex_a.size(); i++) begin
        total++;
        if (wr_a[i] !== ex_a[i] || wr_d[i] !== ex_d[i] || a0[i] !== wr_a[i] || d0[i] !== wr_d[i]) begin
          bad++;
          $display("FAIL thr_word%0d got=%0d/%h exp=%0d/%h", i, wr_a[i], wr_d[i], ex_a[i], ex_d[i]);
        end
      end
    end
    total++;
    if (rdy_viol != 0) begin
      bad++;
      $display("FAIL thr_ready_in_write got=%0d exp=0", rdy_viol);
    end
  endtask

  task automatic test_rst_mid();
    bq_t s, part;
    bit to;
    s = mk(3, 3);
    part = s[0:7];
    pulse_start();
    send_bytes(part, 0, to);
    #2;
    rst = 1'b1;
    #1;
    total++;
    if ({we, in_ready, busy, done, err, core_rst_n} !== 6'b0 || waddr !== '0 || wdata !== 32'd0) begin
      bad++;
      $display("FAIL rst_mid got=%b a%0d d%h exp=000000 a0 d0",
               {we, in_ready, busy, done, err, core_rst_n}, waddr, wdata);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if (busy !== 1'b0 || in_ready !== 1'b0) begin
      bad++;
      $display("FAIL rst_mid_idle got=b%b r%b exp=b0 r0", busy, in_ready);
    end
    s = mk(2, 2);
    model(s);
    clear_obs();
    run_session(s, 2, to);
    total++;
    if (to || wr_a.size() != 2) begin
      bad++;
      $display("FAIL rst_mid_resume got=nwr%0d exp=nwr2", wr_a.size());
    end else begin
      for (int i = 0; i < 2; i++) begin
        total++;
        if (wr_a[i] !== ex_a[i] || wr_d[i] !== ex_d[i]) begin
          bad++;
          $display("FAIL rst_mid_w%0d got=%0d/%h exp=%0d/%h", i, wr_a[i], wr_d[i], ex_a[i], ex_d[i]);
        end
      end
    end
  endtask

  task automatic test_full_depth();
    bq_t s;
    bit to;
    int nbad;
    s = mk(DEPTH, DEPTH);
    model(s);
    clear_obs();
    run_session(s, 2, to);
    total++;
    if (to || wr_a.size() != DEPTH) begin
      bad++;
      $display("FAIL full_nwr got=%0d exp=%0d", wr_a.size(), DEPTH);
    end else begin
      nbad = 0;
      for (int i = 0; i < DEPTH; i++) begin
        total++;
        if (wr_a[i] !== ex_a[i] || wr_d[i] !== ex_d[i]) begin
          bad++;
          if (nbad < 8)
            $display("FAIL full_word%0d got=%0d/%h exp=%0d/%h", i, wr_a[i], wr_d[i], ex_a[i], ex_d[i]);
          nbad++;
        end
      end
      total++;
      if (wr_a[DEPTH-1] !== 10'd1023) begin
        bad++;
        $display("FAIL full_last_addr got=%0d exp=1023", wr_a[DEPTH-1]);
      end
    end
    total++;
    if (done !== 1'b1 || err !== 1'b0 || core_rst_n !== 1'b1) begin
      bad++;
      $display("FAIL full_status got=d%b e%b r%b exp=d1 e0 r1", done, err, core_rst_n);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero_len();
    test_overflow();
    test_start_with_byte();
    test_throttle();
    test_rst_mid();
    test_full_depth();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
